// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write bypass, optional
// registered read stage, per-register busy scoreboard and write-collision flag.
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned READ_LAT = 0,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    input  logic                 flush,
    output logic                 wr_conflict
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             conflict_q;
    logic             conflict_d;

    // Next state: writes (highest port last so it wins), then issue, then flush.
    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        conflict_d = 1'b0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) begin
                regs_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
                busy_d[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        for (int a = 0; a < NWR; a++) begin
            for (int b = a + 1; b < NWR; b++) begin
                if (wr_en[a] && wr_en[b] && (wr_addr[a*AW +: AW] == wr_addr[b*AW +: AW])
                    && !((ZERO_REG != 0) && (wr_addr[a*AW +: AW] == '0))) begin
                    conflict_d = 1'b1;
                end
            end
        end
        if (iss_en) begin
            busy_d[iss_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        if (ZERO_REG != 0) begin
            regs_d[0] = '0;
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign wr_conflict = conflict_q;

    generate
        if (READ_LAT == 0) begin : g_comb_read
            // Stored value, overridden by a same-cycle write, overridden by the zero register.
            always_comb begin
                rd_data = '0;
                rd_busy = '0;
                for (int i = 0; i < NRD; i++) begin
                    rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
                    rd_busy[i]              = busy_q[rd_addr[i*AW +: AW]];
                    if (BYPASS != 0) begin
                        for (int w = 0; w < NWR; w++) begin
                            if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[i*AW +: AW])) begin
                                rd_data[i*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                                rd_busy[i]              = 1'b0;
                            end
                        end
                    end
                    if ((ZERO_REG != 0) && (rd_addr[i*AW +: AW] == '0)) begin
                        rd_data[i*XLEN +: XLEN] = '0;
                        rd_busy[i]              = 1'b0;
                    end
                end
            end
        end else begin : g_reg_read
            logic [NRD*XLEN-1:0] rd_data_q;
            logic [NRD*XLEN-1:0] rd_data_d;
            logic [NRD-1:0]      rd_busy_q;
            logic [NRD-1:0]      rd_busy_d;

            // Registered read returns the post-edge state, so bypass comes for free.
            always_comb begin
                rd_data_d = '0;
                rd_busy_d = '0;
                for (int i = 0; i < NRD; i++) begin
                    rd_data_d[i*XLEN +: XLEN] = regs_d[rd_addr[i*AW +: AW]];
                    rd_busy_d[i]              = busy_d[rd_addr[i*AW +: AW]];
                end
            end

            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    rd_data_q <= '0;
                    rd_busy_q <= '0;
                end else begin
                    rd_data_q <= rd_data_d;
                    rd_busy_q <= rd_busy_d;
                end
            end

            assign rd_data = rd_data_q;
            assign rd_busy = rd_busy_q;
        end
    endgenerate

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, two-read CPU register file.
- Sits in the decode/writeback stage of the pipelined core.
- Adds configurable width, depth, and read/write port counts, plus same-cycle write-to-read bypass and an optional registered read stage.
- Includes a per-register busy scoreboard (set at issue, cleared at writeback) and write-port conflict detection.

Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of registers (power of 2, >= 2); AW = log2(NREGS)
- NRD, 2, number of read ports (1..4)
- NWR, 2, number of write ports (1..2)
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads
- READ_LAT, 0, 0 = combinational read; 1 = registered read

Ports:
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- rd_addr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data per port
- rd_busy  out  NRD  scoreboard busy flag of the addressed register, per port
- wr_en  in  NWR  write enable per port
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- iss_en  in  1  issue strobe: marks iss_addr busy
- iss_addr  in  AW  destination register of the issuing instruction
- flush  in  1  clears all busy bits (pipeline flush)
- wr_conflict  out  1  registered pulse: two write ports targeted the same register in the previous cycle

Behaviour:
- Reset (asynchronous, RESET_N low): all registers 0, all busy bits 0, wr_conflict 0; with READ_LAT=1, rd_data and rd_busy registers 0. Reset asserted mid-operation discards in-flight writes and issues.
- Write: at posedge, for each port w with wr_en[w]=1, reg[wr_addr[w]] <= wr_data[w]. With ZERO_REG=1, writes to address 0 are dropped.
- Write collision: same address on multiple ports → highest-index port wins. wr_conflict=1 in the following cycle only; it is not raised for collisions on register 0 when ZERO_REG=1.
- Read, READ_LAT=0: rd_data[i] is combinational.
  - Returns 0 for address 0 when ZERO_REG=1.
  - Otherwise, with BYPASS=1 and an enabled write to the same address this cycle, returns that write data (highest-index port if several).
  - Otherwise returns the stored value.
  - BYPASS=0: returns the stored (pre-edge) value.
- Read, READ_LAT=1: rd_addr is sampled at posedge; rd_data is valid the next cycle and equals the register value after that edge's writes. Bypass is implicit; the BYPASS parameter is ignored.
- Scoreboard, busy[NREGS], updated at posedge, in priority order:
  1. flush=1 → all busy bits 0; the same-cycle iss_en is ignored.
  2. iss_en=1 → busy[iss_addr] <= 1, even if a write to iss_addr occurs in the same cycle (the new producer wins).
  3. Any enabled write to r → busy[r] <= 0.
- Register 0 is never busy when ZERO_REG=1.
- rd_busy[i] (READ_LAT=0) = busy[rd_addr[i]], masked to 0 when BYPASS=1 and an enabled write hits that address this cycle.
- rd_busy (READ_LAT=1): registered alongside rd_data; reflects the post-edge busy state.
- Writes proceed regardless of the busy state; the scoreboard is advisory to the hazard unit.
- No X propagation: all outputs are defined for all address values.

Test Plan:
- Reset, then read all 32 addresses on both ports → rd_data=0, rd_busy=0; with READ_LAT=1, same result one cycle later.
- Write port0 reg5=0xDEADBEEF; next cycle read reg5 → 0xDEADBEEF. Write reg0=0x1234 → reg0 still reads 0 and wr_conflict stays 0.
- BYPASS=1, READ_LAT=0: in the same cycle, write reg7=0xA5A5A5A5 and read reg7 → 0xA5A5A5A5 combinationally. With BYPASS=0 → reads the old value 0.
- Both write ports hit reg3 (port0=0x11, port1=0x22) → reg3=0x22; wr_conflict=1 for exactly one cycle.
- iss_en reg9 → rd_busy=1 from the next cycle. Write reg9=0x5 → busy clears; the same-cycle read shows rd_busy=0 and data 0x5. iss_en and a write to reg9 in the same cycle → busy remains 1.
- Set busy on reg4 and reg6, assert flush together with iss_en reg8 → all busy bits 0, including reg8. Assert RESET_N low mid-write → registers return to 0 immediately.
